// File: rtl/tdp_ram_pkg.sv
// Shared types for the dual-port RAM arbiter.
// FSM states, default widths, drain length and pipeline slot.
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    CLR,
    INIT,
    RUN,
    DRAIN
  } state_e;

  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 8;
  localparam int DRAIN_CYC = 2;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);

  // Requester id field is sized for the largest NREQ (8).
  localparam int IDW = 3;

  typedef struct packed {
    logic           v;
    logic           we;
    logic [IDW-1:0] id;
  } slot_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-grant round-robin picker with same-address conflict check.
// In: req_i/we_i/addr_i/ptr_i. Out: A and B grants, next pointer.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 6
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         we_i,
  input  logic [NREQ*AW-1:0]      addr_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    a_v_o,
  output logic [$clog2(NREQ)-1:0] a_id_o,
  output logic                    b_v_o,
  output logic [$clog2(NREQ)-1:0] b_id_o,
  output logic [$clog2(NREQ)-1:0] ptr_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] idx;
  logic          done;
  logic          clash;

  always_comb begin
    a_v_o  = 1'b0;
    a_id_o = '0;
    b_v_o  = 1'b0;
    b_id_o = '0;
    ptr_o  = ptr_i;
    idx    = '0;
    done   = 1'b0;
    clash  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr_i) + i) % NREQ);
      if (req_i[idx] && !done) begin
        if (!a_v_o) begin
          a_v_o  = 1'b1;
          a_id_o = idx;
          ptr_o  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end else begin
          // Second candidate: grant on B or defer; either way stop.
          done  = 1'b1;
          clash = (addr_i[idx*AW +: AW] == addr_i[a_id_o*AW +: AW])
                  && (we_i[idx] || we_i[a_id_o]);
          if (!clash) begin
            b_v_o  = 1'b1;
            b_id_o = idx;
            ptr_o  = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tdp_ram_arbiter.sv
// Arbitrates NREQ clients onto a true-dual-port RAM, zero-fills it.
// Ports: req_* in, req_ready/rsp_* out, ram_* to the RAM instance.
module tdp_ram_arbiter
  import tdp_ram_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_req,
  output logic               init_done,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_din_a,
  output logic [DW-1:0]      ram_din_b,
  output logic               ram_we_a,
  output logic               ram_we_b,
  output logic               ram_sclr,
  input  logic [DW-1:0]      ram_dout_a,
  input  logic [DW-1:0]      ram_dout_b
);

  localparam int IW = $clog2(NREQ);
  localparam int FW = AW - 1;

  state_e state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] din_a_q, din_a_d;
  logic [DW-1:0] din_b_q, din_b_d;
  logic          we_a_q, we_a_d;
  logic          we_b_q, we_b_d;
  logic          sclr_q, sclr_d;

  slot_t         s1_a_q, s1_a_d;
  slot_t         s1_b_q, s1_b_d;
  slot_t         s2_a_q, s2_b_q;
  logic [DW-1:0] s2_wd_a_q, s2_wd_b_q;

  logic          a_v, b_v, ga, gb;
  logic [IW-1:0] a_id, b_id, ptr_nxt;

  rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW)
  ) u_pick (
    .req_i  (req_valid),
    .we_i   (req_we),
    .addr_i (req_addr),
    .ptr_i  (rr_ptr_q),
    .a_v_o  (a_v),
    .a_id_o (a_id),
    .b_v_o  (b_v),
    .b_id_o (b_id),
    .ptr_o  (ptr_nxt)
  );

  assign init_done = (state_q == RUN);
  assign ga        = a_v && init_done;
  assign gb        = b_v && init_done;

  assign ram_addr_a = addr_a_q;
  assign ram_addr_b = addr_b_q;
  assign ram_din_a  = din_a_q;
  assign ram_din_b  = din_b_q;
  assign ram_we_a   = we_a_q;
  assign ram_we_b   = we_b_q;
  assign ram_sclr   = sclr_q;

  always_comb begin
    req_ready = '0;
    if (ga) req_ready[a_id] = 1'b1;
    if (gb) req_ready[b_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    drain_d  = drain_q;
    rr_ptr_d = ga ? ptr_nxt : rr_ptr_q;
    unique case (state_q)
      CLR: begin
        state_d = INIT;
        fill_d  = '0;
      end
      INIT: begin
        fill_d = fill_q + 1'b1;
        if (&fill_q) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = CLR;
      end
      default: state_d = CLR;
    endcase
    // Clear pulse is low exactly while the FSM sits in CLR.
    sclr_d = (state_d != CLR);
  end

  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    din_a_d  = din_a_q;
    din_b_d  = din_b_q;
    we_a_d   = 1'b1;
    we_b_d   = 1'b1;
    if (state_q == INIT) begin
      addr_a_d = {fill_q, 1'b0};
      addr_b_d = {fill_q, 1'b1};
      din_a_d  = '0;
      din_b_d  = '0;
      we_a_d   = 1'b0;
      we_b_d   = 1'b0;
    end else begin
      if (ga) begin
        addr_a_d = req_addr[a_id*AW +: AW];
        din_a_d  = req_wdata[a_id*DW +: DW];
        we_a_d   = ~req_we[a_id];
      end
      if (gb) begin
        addr_b_d = req_addr[b_id*AW +: AW];
        din_b_d  = req_wdata[b_id*DW +: DW];
        we_b_d   = ~req_we[b_id];
      end
    end
    s1_a_d = '{v: ga, we: req_we[a_id], id: IDW'(a_id)};
    s1_b_d = '{v: gb, we: req_we[b_id], id: IDW'(b_id)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLR;
      fill_q    <= '0;
      drain_q   <= '0;
      rr_ptr_q  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      din_a_q   <= '0;
      din_b_q   <= '0;
      we_a_q    <= 1'b1;
      we_b_q    <= 1'b1;
      sclr_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      s2_wd_a_q <= '0;
      s2_wd_b_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      din_a_q   <= din_a_d;
      din_b_q   <= din_b_d;
      we_a_q    <= we_a_d;
      we_b_q    <= we_b_d;
      sclr_q    <= sclr_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s2_a_q    <= s1_a_q;
      s2_b_q    <= s1_b_q;
      s2_wd_a_q <= din_a_q;
      s2_wd_b_q <= din_b_q;
    end
  end

  // Writes echo their own data; reads take the RAM output directly.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (s2_a_q.v && s2_a_q.id == IDW'(i)) begin
        rsp_valid[i]           = 1'b1;
        rsp_rdata[i*DW +: DW]  = s2_a_q.we ? s2_wd_a_q : ram_dout_a;
      end
      if (s2_b_q.v && s2_b_q.id == IDW'(i)) begin
        rsp_valid[i]           = 1'b1;
        rsp_rdata[i*DW +: DW]  = s2_b_q.we ? s2_wd_b_q : ram_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Bench for tdp_ram_arbiter with a behavioural dual-port RAM.
// Vector table for arbitration/data, directed sequences for FSM.
module tb_tdp_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        init_done;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [5:0]  ram_addr_a, ram_addr_b;
  logic [7:0]  ram_din_a, ram_din_b;
  logic        ram_we_a, ram_we_b, ram_sclr;
  logic [7:0]  ram_dout_a, ram_dout_b;

  int n_cmp = 0;
  int n_bad = 0;

  tdp_ram_arbiter #(
    .NREQ (4),
    .AW   (6),
    .DW   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_din_a  (ram_din_a),
    .ram_din_b  (ram_din_b),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_sclr   (ram_sclr),
    .ram_dout_a (ram_dout_a),
    .ram_dout_b (ram_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: port A on rising edge, port B on falling edge, write-first.
  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
    ram_dout_a = 8'h00;
    ram_dout_b = 8'h00;
  end
  always @(clk) begin
    if (clk) begin
      if (!ram_we_a) mem[ram_addr_a] <= ram_din_a;
      ram_dout_a <= !ram_sclr ? 8'h00 :
                    (!ram_we_a ? ram_din_a : mem[ram_addr_a]);
    end else begin
      if (!ram_we_b) mem[ram_addr_b] <= ram_din_b;
      ram_dout_b <= !ram_sclr ? 8'h00 :
                    (!ram_we_b ? ram_din_b : mem[ram_addr_b]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [23:0] addr;
    logic [31:0] wd;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [18];

  function automatic logic [23:0] pa(input int a0, a1, a2, a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [31:0] pd(input int d0, d1, d2, d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] rv);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (rv[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Entered at +1 of the CLR cycle; leaves at +3 of the first RUN cycle.
  task automatic wait_init(input string tag);
    int cyc;
    #2;
    chk({tag, "_clr_sclr"}, 64'(ram_sclr), 0);
    chk({tag, "_clr_done"}, 64'(init_done), 0);
    chk({tag, "_clr_rsp"}, 64'(rsp_valid), 0);
    tick();
    #2;
    cyc = 2;
    chk({tag, "_init_sclr"}, 64'(ram_sclr), 1);
    while (!init_done && cyc < 100) begin
      if (cyc == 3) begin
        chk({tag, "_fill_first"},
            64'({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b}),
            64'({2'b00, 6'd0, 6'd1}));
        req_valid = '1;
        #1;
        chk({tag, "_init_rdy"}, 64'(req_ready), 0);
        req_valid = '0;
      end
      tick();
      #2;
      cyc++;
    end
    chk({tag, "_init_cycle"}, 64'(cyc), 34);
    chk({tag, "_fill_last"},
        64'({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b}),
        64'({2'b00, 6'd62, 6'd63}));
  endtask

  initial begin
    tv[0]  = '{4'hF, 4'h0, pa(5, 40, 9, 10), '0, 4'h3, 4'h0, '0};
    tv[1]  = '{4'hF, 4'h0, pa(5, 40, 9, 10), '0, 4'hC, 4'h0, '0};
    tv[2]  = '{4'hF, 4'h0, pa(5, 40, 9, 10), '0, 4'h3, 4'h3, '0};
    tv[3]  = '{4'hC, 4'hC, pa(0, 0, 9, 10), pd(0, 0, 'hA2, 'hB3),
               4'hC, 4'hC, '0};
    tv[4]  = '{4'h1, 4'h1, pa(3, 0, 0, 0), pd('h5A, 0, 0, 0),
               4'h1, 4'h3, '0};
    tv[5]  = '{4'h1, 4'h0, pa(3, 0, 0, 0), '0, 4'h1, 4'hC,
               pd(0, 0, 'hA2, 'hB3)};
    tv[6]  = '{4'hF, 4'h0, pa(9, 10, 3, 5), '0, 4'h6, 4'h1,
               pd('h5A, 0, 0, 0)};
    tv[7]  = '{4'hF, 4'h0, pa(9, 10, 3, 5), '0, 4'h9, 4'h1,
               pd('h5A, 0, 0, 0)};
    tv[8]  = '{4'h0, 4'h0, '0, '0, 4'h0, 4'h6, pd(0, 'hB3, 'h5A, 0)};
    tv[9]  = '{4'h0, 4'h0, '0, '0, 4'h0, 4'h9, pd('hA2, 0, 0, 0)};
    tv[10] = '{4'hC, 4'h0, pa(0, 0, 20, 21), '0, 4'hC, 4'h0, '0};
    tv[11] = '{4'h3, 4'h1, pa(7, 7, 0, 0), pd('h11, 0, 0, 0),
               4'h1, 4'h0, '0};
    tv[12] = '{4'h2, 4'h0, pa(0, 7, 0, 0), '0, 4'h2, 4'hC, '0};
    tv[13] = '{4'h0, 4'h0, '0, '0, 4'h0, 4'h1, pd('h11, 0, 0, 0)};
    tv[14] = '{4'h0, 4'h0, '0, '0, 4'h0, 4'h2, pd(0, 'h11, 0, 0)};
    tv[15] = '{4'hC, 4'h0, pa(0, 0, 3, 3), '0, 4'hC, 4'h0, '0};
    tv[16] = '{4'h0, 4'h0, '0, '0, 4'h0, 4'h0, '0};
    tv[17] = '{4'h0, 4'h0, '0, '0, 4'h0, 4'hC, pd(0, 0, 'h5A, 'h5A)};

    rst       = 1'b1;
    clear_req = 1'b0;
    idle_in();

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    chk("rst_done", 64'(init_done), 0);
    chk("rst_ram", 64'({ram_we_a, ram_we_b, ram_sclr, ram_addr_a,
                        ram_din_a}), 64'({3'b110, 6'd0, 8'd0}));
    chk("rst_rsp", 64'({rsp_valid, rsp_rdata}), 0);
    tick();
    rst = 1'b0;
    wait_init("t1");

    // Arbitration and data vectors.
    tick();
    for (int k = 0; k < 18; k++) begin
      req_valid = tv[k].v;
      req_we    = tv[k].we;
      req_addr  = tv[k].addr;
      req_wdata = tv[k].wd;
      #2;
      chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tv[k].rdy));
      chk($sformatf("v%0d_rspv", k), 64'(rsp_valid), 64'(tv[k].rv));
      chk($sformatf("v%0d_rdata", k),
          64'(rsp_rdata & lane_mask(tv[k].rv)),
          64'(tv[k].rd & lane_mask(tv[k].rv)));
      tick();
    end

    // Clear with two reads in flight.
    req_valid = 4'h3;
    req_addr  = pa(3, 9, 0, 0);
    #2;
    chk("clr_hs_rdy", 64'(req_ready), 64'(4'h3));
    tick();
    idle_in();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    req_valid = 4'hF;
    #2;
    chk("drain1_rdy", 64'(req_ready), 0);
    chk("drain1_rspv", 64'(rsp_valid), 64'(4'h3));
    chk("drain1_data", 64'(rsp_rdata[15:0]), 64'(16'hA25A));
    tick();
    #2;
    chk("drain2_rdy", 64'(req_ready), 0);
    chk("drain2_rspv", 64'(rsp_valid), 0);
    idle_in();
    tick();
    wait_init("t5");
    tick();
    req_valid = 4'h3;
    req_addr  = pa(3, 9, 0, 0);
    #2;
    chk("rezero_rdy", 64'(req_ready), 64'(4'h3));
    tick();
    idle_in();
    tick();
    #2;
    chk("rezero_rspv", 64'(rsp_valid), 64'(4'h3));
    chk("rezero_data", 64'(rsp_rdata[15:0]), 0);

    // Reset one cycle after a handshake.
    tick();
    req_valid = 4'h1;
    req_addr  = pa(3, 0, 0, 0);
    #2;
    chk("rst6_rdy", 64'(req_ready), 64'(4'h1));
    tick();
    idle_in();
    rst = 1'b1;
    #2;
    chk("rst6_rspv", 64'(rsp_valid), 0);
    chk("rst6_done", 64'(init_done), 0);
    tick();
    rst = 1'b0;
    wait_init("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
